conv_encoder: RTL

Rate-1/2 convolutional encoder stage (K=7, generators 171/133 octal) that sits directly downstream of circular_buffer in the FEC encoder.
- Pulls one message_data_t word at a time through the buffer's rd_en/rd_valid interface.
- Serialises each word MSB-first and emits one 2-bit coded symbol per message bit over a valid/ready handshake to the modulator/framer side.

---
 rtl/encoder_fec_pkg.sv | 33 +++
 rtl/conv_encoder_core.sv | 35 +++
 rtl/conv_encoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/encoder_fec_pkg.sv
// Shared types and constants for the FEC encoder chain.
// Carries the K=7 rate-1/2 convolutional code parameters and encoder FSM states.
package encoder_fec_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] message_data_t;

  localparam int CONV_K        = 7;
  localparam int CONV_MEM      = CONV_K - 1;
  localparam int CONV_TAIL_LEN = CONV_MEM;

  localparam logic [CONV_K-1:0] CONV_G0 = 7'o171;
  localparam logic [CONV_K-1:0] CONV_G1 = 7'o133;

  typedef logic [1:0] coded_sym_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DATA,
    TAIL
  } conv_state_t;

  function automatic logic conv_parity(
    input logic [CONV_K-1:0] w,
    input logic [CONV_K-1:0] g
  );
    return ^(w & g);
  endfunction

endpackage

// File: rtl/conv_encoder_core.sv
// K=7 shift register and generator parity for the convolutional encoder.
// Ports: clk, rst_n (sync, active-low), advance, u, clr in; sym = {G0 bit, G1 bit} out.
import encoder_fec_pkg::*;

module conv_encoder_core #(
  parameter logic [CONV_K-1:0] G0_POLY = CONV_G0,
  parameter logic [CONV_K-1:0] G1_POLY = CONV_G1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       u,
  input  logic       clr,
  output coded_sym_t sym
);

  logic [CONV_MEM-1:0] shreg;
  logic [CONV_K-1:0]   window;

  // Newest bit enters at the top, oldest falls off bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (clr) begin
      shreg <= '0;
    end else if (advance) begin
      shreg <= {u, shreg[CONV_MEM-1:1]};
    end
  end

  assign window = {u, shreg};
  assign sym    = {conv_parity(window, G0_POLY),
                   conv_parity(window, G1_POLY)};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder pulling words from circular_buffer.
// Ports: clk, rst_n, buf_empty/buf_rd_valid/buf_data in, buf_rd_en out;
// sym_out/sym_valid/sym_last out, sym_ready in; busy out.
// Macro FEC_TAIL_EN: append 6 zero tail bits so each message terminates.
import encoder_fec_pkg::*;

module conv_encoder #(
  parameter int                DATA_WIDTH = encoder_fec_pkg::DATA_WIDTH,
  parameter logic [CONV_K-1:0] G0_POLY    = 7'o171,
  parameter logic [CONV_K-1:0] G1_POLY    = 7'o133
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  buf_empty,
  input  logic                  buf_rd_valid,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic                  buf_rd_en,
  output logic [1:0]            sym_out,
  output logic                  sym_valid,
  input  logic                  sym_ready,
  output logic                  sym_last,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + CONV_TAIL_LEN);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_TAIL = CW'(CONV_TAIL_LEN - 1);

  conv_state_t           fsm;
  logic [DATA_WIDTH-1:0] msg_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  hs;
  logic                  u;
  logic                  clr;

  // Message is shifted left per accepted symbol, so the MSB is always
  // the current input bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      msg_reg <= '0;
      bit_cnt <= '0;
    end else begin
      unique case (fsm)
        IDLE: if (!buf_empty) fsm <= REQ;
        REQ, WAIT: begin
          if (buf_rd_valid) begin
            msg_reg <= buf_data;
            bit_cnt <= '0;
            fsm     <= DATA;
          end else begin
            fsm <= WAIT;
          end
        end
        DATA: begin
          if (hs) begin
            msg_reg <= msg_reg << 1;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef FEC_TAIL_EN
              fsm     <= TAIL;
`else
              fsm     <= IDLE;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        TAIL: begin
          if (hs) begin
            if (bit_cnt == LAST_TAIL) begin
              bit_cnt <= '0;
              fsm     <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign sym_valid = (fsm == DATA) || (fsm == TAIL);
  assign hs        = sym_valid && sym_ready;
  assign u         = (fsm == DATA) && msg_reg[DATA_WIDTH-1];
  assign buf_rd_en = (fsm == REQ);
  assign busy      = (fsm != IDLE);

`ifdef FEC_TAIL_EN
  assign sym_last = (fsm == TAIL) && (bit_cnt == LAST_TAIL);
  assign clr      = (fsm == IDLE);
`else
  assign sym_last = (fsm == DATA) && (bit_cnt == LAST_DATA);
  assign clr      = 1'b0;
`endif

  conv_encoder_core #(
    .G0_POLY(G0_POLY),
    .G1_POLY(G1_POLY)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (hs),
    .u       (u),
    .clr     (clr),
    .sym     (sym_out)
  );

endmodule
